as6s_vp_buffer_fifo_ctrl: RTL and testbench
===========================================

# as6s_vp_buffer_fifo_ctrl

FIFO controller that sits directly upstream of the 2048x128 1R1W ECC-protected buffer RAM wrapper. It turns a valid/ready write stream and a valid/ready read stream into RAM port commands (AA_F/CSA_F/WEA_F/DA_F, CSB_F/REB_F/AB_F). It absorbs the wrapper's 2-cycle read latency with a credit-controlled prefetch buffer. It also tags each popped word with the wrapper's ECC status and keeps sticky error statistics.

## Interface
- ADDR_WIDTH, 11: RAM address width; RAM_DEPTH = 1<<ADDR_WIDTH.
- DATA_WIDTH, 128: payload width.
- RD_LATENCY, 2: cycles from CSB_F/REB_F issue to QB_F/error flags valid.
- PREFETCH_DEPTH, 4: prefetch entries. Must be >= RD_LATENCY+2.
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- wr_valid / wr_ready  in/out  1  write handshake.
- wr_data  in  DATA_WIDTH  write payload.
- rd_valid / rd_ready  out/in  1  read handshake.
- rd_data  out  DATA_WIDTH  head word.
- rd_sbit_err, rd_dbit_err, rd_ecc_fault  out  1  ECC status of the head word.
- AA_F  out  ADDR_WIDTH  RAM write address.
- CSA_F, WEA_F  out  1  RAM write port controls.
- DA_F  out  DATA_WIDTH  RAM write data.
- AB_F  out  ADDR_WIDTH  RAM read address.
- CSB_F, REB_F  out  1  RAM read port controls.
- QB_F  in  DATA_WIDTH  RAM read data.
- SINGLE_ERR_B, DOUBLE_ERR_B, ECC_FAULT_B  in  1  RAM ECC status, aligned with QB_F.
- fill_level  out  ADDR_WIDTH+2  total words held (RAM + in flight + prefetch).
- sbit_cnt, dbit_cnt  out  16  saturating error counters.
- ecc_fault_sticky  out  1  set on any popped ECC fault.
- stat_clr  in  1  synchronous clear of the counters and the sticky flag.

## Operation
- **Write.** A write occurs when wr_valid & wr_ready.
  - Same cycle: CSA_F=WEA_F=1, AA_F=wptr, DA_F=wr_data.
  - wptr increments modulo RAM_DEPTH.
  - wr_ready = (ram_cnt < RAM_DEPTH). It is combinational from registered state only.
- **Read issue.** A read is issued when ram_cnt>0 and (pf_cnt + inflight) < PREFETCH_DEPTH.
  - Same cycle: CSB_F=REB_F=1, AB_F=rptr.
  - rptr increments modulo RAM_DEPTH.
  - A word written in cycle N becomes readable from cycle N+1 (ram_cnt updates at the edge).
  - Consequently AB_F never equals AA_F during a simultaneous valid write. The only equal-address case is full RAM, and then wr_ready=0.
- **Return tracking.** A RD_LATENCY-deep valid shift register tracks in-flight reads.
  - When the tap is set, {QB_F, SINGLE_ERR_B, DOUBLE_ERR_B, ECC_FAULT_B} is pushed into the prefetch FIFO.
  - The credit rule guarantees the prefetch FIFO never overflows. Overflow is an assertion failure.
- **Pop.**
  - rd_valid = pf_cnt>0.
  - rd_data and the status bits come from the prefetch head.
  - A pop occurs on rd_valid & rd_ready.
- **Statistics.** These update on pop only:
  - sbit_cnt increments when rd_sbit_err; dbit_cnt increments when rd_dbit_err. Both saturate at 16'hFFFF.
  - ecc_fault_sticky is set when rd_ecc_fault.
  - stat_clr has priority over a same-cycle increment: the result is 0.
- **Counters.**
  - ram_cnt changes by +write −issue.
  - fill_level = ram_cnt + inflight + pf_cnt, all registered.
  - Simultaneous write and issue leaves ram_cnt unchanged.
- **Idle outputs.** When no command is issued, CSA_F, WEA_F, CSB_F and REB_F are 0. Address/data hold their last value.

## Timing
- Reset values:
  - Pointers, ram_cnt, inflight and pf_cnt are 0.
  - wr_ready=1 after reset release. rd_valid=0.
  - All RAM control strobes are 0.
  - fill_level, counters and the sticky flag are 0.
  - rd_data and AA_F/AB_F/DA_F are 0.
- Latency on an empty FIFO (0-based cycles):
  - Write in cycle 0, issue in cycle 1, QB_F valid in cycle 3.
  - rd_valid=1 in cycle 4.
- Throughput: one write and one pop per cycle, sustained, once PREFETCH_DEPTH >= RD_LATENCY+2.
- Reset mid-operation: all state clears immediately. In-flight RAM returns arriving after reset release are ignored because the shift register is cleared. RAM contents are not cleared.
- fill_level reaches RAM_DEPTH+PREFETCH_DEPTH maximum. Its width must hold that value.

## Structure
- Shared package as6s_vp_buffer_pkg holds the following. Module parameters default from these constants.
  - constants VPB_ADDR_WIDTH=11, VPB_DATA_WIDTH=128, VPB_RD_LATENCY=2.
  - typedef of the prefetch entry: {data, sbit, dbit, fault}.
- One sub-module: as6s_vp_buffer_pf_fifo. It is a register-based synchronous FIFO of width DATA_WIDTH+3 and depth PREFETCH_DEPTH, exposing count.

## Test plan
- **Single word.** Reset, write 128'hA5 in cycle 0.
  - AA_F=0, CSA_F=WEA_F=1 in cycle 0; AB_F=0, CSB_F=REB_F=1 in cycle 1.
  - rd_valid in cycle 4 with rd_data=128'hA5.
  - fill_level=1 through the pop.
- **Fill to full.** Hold rd_ready=0 and write 2052 words.
  - wr_ready drops after word 2052 (2048 RAM + 4 prefetch).
  - fill_level=2052. No read is issued at the AA_F address.
- **Wrap-around.** Stream 5000 words with rd_ready=1 throughout.
  - Output equals input in order. Pointers wrap 2047→0.
  - After the 4-cycle fill latency, one word per cycle.
- **ECC tagging.** Force SINGLE_ERR_B=1 on the 3rd return and DOUBLE_ERR_B=1 plus ECC_FAULT_B=1 on the 5th.
  - The flags appear with popped words 3 and 5.
  - sbit_cnt=1, dbit_cnt=1, ecc_fault_sticky=1.
  - stat_clr then yields 0, 0, 0.
- **Backpressure.** Toggle rd_ready 1/0 randomly with 30% stall.
  - The prefetch FIFO never exceeds 4. No data is lost.
- **Reset mid-operation.** Assert rst with 2 reads in flight.
  - Outputs go to their reset values immediately.
  - Stale QB_F returns are not pushed, and rd_valid stays 0.

Source files
------------

// File: rtl/as6s_vp_buffer_pkg.sv
// Shared constants and the prefetch entry layout for the video-pipe buffer FIFO controller.
package as6s_vp_buffer_pkg;

  localparam int VPB_ADDR_WIDTH     = 11;
  localparam int VPB_DATA_WIDTH     = 128;
  localparam int VPB_RD_LATENCY     = 2;
  localparam int VPB_PREFETCH_DEPTH = 4;

  typedef struct packed {
    logic [VPB_DATA_WIDTH-1:0] data;
    logic                      sbit;
    logic                      dbit;
    logic                      fault;
  } vpb_pf_entry_t;

endpackage

// File: rtl/as6s_vp_buffer_pf_fifo.sv
// Register-based prefetch FIFO that absorbs RAM read returns ahead of the consumer.
module as6s_vp_buffer_pf_fifo
  import as6s_vp_buffer_pkg::*;
#(
  parameter int WIDTH = VPB_DATA_WIDTH + 3,
  parameter int DEPTH = VPB_PREFETCH_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[tail] <= din;
        tail      <= ptr_inc(tail);
      end
      if (pop) head <= ptr_inc(head);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  assign dout = mem[head];

  // The upstream credit rule must keep these from ever firing.
  overflow_chk:  assert property (@(posedge clk) disable iff (rst) push |-> (count < CW'(DEPTH)));
  underflow_chk: assert property (@(posedge clk) disable iff (rst) pop  |-> (count != '0));

endmodule

// File: rtl/as6s_vp_buffer_fifo_ctrl.sv
// Valid/ready FIFO front-end for the 1R1W ECC buffer RAM: issues RAM commands,
// hides read latency behind a credit-controlled prefetch FIFO, tracks ECC statistics.
module as6s_vp_buffer_fifo_ctrl
  import as6s_vp_buffer_pkg::*;
#(
  parameter int ADDR_WIDTH     = VPB_ADDR_WIDTH,
  parameter int DATA_WIDTH     = VPB_DATA_WIDTH,
  parameter int RD_LATENCY     = VPB_RD_LATENCY,
  parameter int PREFETCH_DEPTH = VPB_PREFETCH_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_sbit_err,
  output logic                  rd_dbit_err,
  output logic                  rd_ecc_fault,
  output logic [ADDR_WIDTH-1:0] AA_F,
  output logic                  CSA_F,
  output logic                  WEA_F,
  output logic [DATA_WIDTH-1:0] DA_F,
  output logic [ADDR_WIDTH-1:0] AB_F,
  output logic                  CSB_F,
  output logic                  REB_F,
  input  logic [DATA_WIDTH-1:0] QB_F,
  input  logic                  SINGLE_ERR_B,
  input  logic                  DOUBLE_ERR_B,
  input  logic                  ECC_FAULT_B,
  output logic [ADDR_WIDTH+1:0] fill_level,
  output logic [15:0]           sbit_cnt,
  output logic [15:0]           dbit_cnt,
  output logic                  ecc_fault_sticky,
  input  logic                  stat_clr
);

  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
  localparam int PF_CW     = $clog2(PREFETCH_DEPTH + 1);
  localparam int IF_CW     = $clog2(RD_LATENCY + 1);
  localparam int CR_W      = $clog2(PREFETCH_DEPTH + RD_LATENCY + 1);
  localparam int FL_W      = ADDR_WIDTH + 2;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  sbit;
    logic                  dbit;
    logic                  fault;
  } entry_t;

  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic [ADDR_WIDTH-1:0] aa_q;
  logic [ADDR_WIDTH-1:0] ab_q;
  logic [DATA_WIDTH-1:0] da_q;
  logic [ADDR_WIDTH:0]   ram_cnt;
  logic [RD_LATENCY-1:0] rd_vld_p;
  logic [IF_CW-1:0]      inflight;
  logic [PF_CW-1:0]      pf_cnt;
  logic [CR_W-1:0]       credit_used;
  logic                  wr_fire;
  logic                  rd_issue;
  logic                  pf_push;
  logic                  pop;
  entry_t                pf_din;
  entry_t                pf_dout;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + IF_CW'(rd_vld_p[i]);
  end

  // Issue only while every outstanding read is guaranteed a prefetch slot.
  assign credit_used = CR_W'(pf_cnt) + CR_W'(inflight);
  assign wr_ready    = (ram_cnt < (ADDR_WIDTH + 1)'(RAM_DEPTH));
  assign wr_fire     = wr_valid & wr_ready;
  assign rd_issue    = (ram_cnt != '0) && (credit_used < CR_W'(PREFETCH_DEPTH));

  assign CSA_F = wr_fire;
  assign WEA_F = wr_fire;
  assign AA_F  = wr_fire ? wptr : aa_q;
  assign DA_F  = wr_fire ? wr_data : da_q;
  assign CSB_F = rd_issue;
  assign REB_F = rd_issue;
  assign AB_F  = rd_issue ? rptr : ab_q;

  assign fill_level = FL_W'(ram_cnt) + FL_W'(inflight) + FL_W'(pf_cnt);

  // Command stage: pointers, occupancy and the in-flight valid pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      aa_q     <= '0;
      ab_q     <= '0;
      da_q     <= '0;
      ram_cnt  <= '0;
      rd_vld_p <= '0;
    end else begin
      if (wr_fire) begin
        wptr <= wptr + ADDR_WIDTH'(1);
        aa_q <= wptr;
        da_q <= wr_data;
      end
      if (rd_issue) begin
        rptr <= rptr + ADDR_WIDTH'(1);
        ab_q <= rptr;
      end
      case ({wr_fire, rd_issue})
        2'b10:   ram_cnt <= ram_cnt + (ADDR_WIDTH + 1)'(1);
        2'b01:   ram_cnt <= ram_cnt - (ADDR_WIDTH + 1)'(1);
        default: ;
      endcase
      rd_vld_p[0] <= rd_issue;
      for (int i = 1; i < RD_LATENCY; i++) rd_vld_p[i] <= rd_vld_p[i-1];
    end
  end

  // Return stage: the last pipeline tap lines up with QB_F and its ECC flags.
  assign pf_push = rd_vld_p[RD_LATENCY-1];
  assign pf_din  = '{data: QB_F, sbit: SINGLE_ERR_B, dbit: DOUBLE_ERR_B, fault: ECC_FAULT_B};

  as6s_vp_buffer_pf_fifo #(
    .WIDTH (DATA_WIDTH + 3),
    .DEPTH (PREFETCH_DEPTH)
  ) u_pf_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (pf_push),
    .din   (pf_din),
    .pop   (pop),
    .dout  (pf_dout),
    .count (pf_cnt)
  );

  assign rd_valid     = (pf_cnt != '0);
  assign pop          = rd_valid & rd_ready;
  assign rd_data      = pf_dout.data;
  assign rd_sbit_err  = pf_dout.sbit;
  assign rd_dbit_err  = pf_dout.dbit;
  assign rd_ecc_fault = pf_dout.fault;

  // Pop stage: statistics follow what the consumer actually takes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sbit_cnt         <= '0;
      dbit_cnt         <= '0;
      ecc_fault_sticky <= 1'b0;
    end else if (stat_clr) begin
      sbit_cnt         <= '0;
      dbit_cnt         <= '0;
      ecc_fault_sticky <= 1'b0;
    end else if (pop) begin
      if (rd_sbit_err)  sbit_cnt <= sat_inc16(sbit_cnt);
      if (rd_dbit_err)  dbit_cnt <= sat_inc16(dbit_cnt);
      if (rd_ecc_fault) ecc_fault_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_as6s_vp_buffer_fifo_ctrl.sv
// Directed bench for as6s_vp_buffer_fifo_ctrl with a behavioural 2-cycle ECC RAM model.
`timescale 1ns/1ps
module tb_as6s_vp_buffer_fifo_ctrl;
  import as6s_vp_buffer_pkg::*;

  localparam int AW    = VPB_ADDR_WIDTH;
  localparam int DW    = VPB_DATA_WIDTH;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_valid = 1'b0, wr_ready;
  logic [DW-1:0] wr_data = '0;
  logic          rd_valid, rd_ready = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_sbit_err, rd_dbit_err, rd_ecc_fault;
  logic [AW-1:0] AA_F, AB_F;
  logic          CSA_F, WEA_F, CSB_F, REB_F;
  logic [DW-1:0] DA_F, QB_F;
  logic          SINGLE_ERR_B, DOUBLE_ERR_B, ECC_FAULT_B;
  logic [AW+1:0] fill_level;
  logic [15:0]   sbit_cnt, dbit_cnt;
  logic          ecc_fault_sticky;
  logic          stat_clr = 1'b0;

  always #5 clk = ~clk;

  as6s_vp_buffer_fifo_ctrl dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .rd_sbit_err(rd_sbit_err), .rd_dbit_err(rd_dbit_err), .rd_ecc_fault(rd_ecc_fault),
    .AA_F(AA_F), .CSA_F(CSA_F), .WEA_F(WEA_F), .DA_F(DA_F),
    .AB_F(AB_F), .CSB_F(CSB_F), .REB_F(REB_F), .QB_F(QB_F),
    .SINGLE_ERR_B(SINGLE_ERR_B), .DOUBLE_ERR_B(DOUBLE_ERR_B), .ECC_FAULT_B(ECC_FAULT_B),
    .fill_level(fill_level), .sbit_cnt(sbit_cnt), .dbit_cnt(dbit_cnt),
    .ecc_fault_sticky(ecc_fault_sticky), .stat_clr(stat_clr)
  );

  // RAM model: write at the edge, read data and ECC flags two edges after issue.
  logic [DW-1:0] mem [DEPTH];
  bit            v_p1;
  logic [AW-1:0] ab_p1;
  int            ret_cnt;
  int            inj_s = -1;
  int            inj_d = -1;

  always @(posedge clk) begin
    if (CSA_F && WEA_F) mem[AA_F] <= DA_F;
    v_p1  <= CSB_F && REB_F;
    ab_p1 <= AB_F;
    SINGLE_ERR_B <= 1'b0;
    DOUBLE_ERR_B <= 1'b0;
    ECC_FAULT_B  <= 1'b0;
    if (v_p1) begin
      QB_F         <= mem[ab_p1];
      SINGLE_ERR_B <= (ret_cnt == inj_s);
      DOUBLE_ERR_B <= (ret_cnt == inj_d);
      ECC_FAULT_B  <= (ret_cnt == inj_d);
      ret_cnt      <= ret_cnt + 1;
    end
  end

  int checks   = 0;
  int failures = 0;
  logic [DW-1:0] q[$];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input string name, input int budget);
    int cyc = 0;
    int bad = 0;
    wr_valid = 1'b0;
    rd_ready = 1'b1;
    while (q.size() > 0 && cyc < budget) begin
      #1;
      if (rd_valid) begin
        if (rd_data !== q[0]) bad++;
        void'(q.pop_front());
      end
      step();
      cyc++;
    end
    chk({name, ".left"}, DW'(q.size()), '0);
    chk({name, ".order_errs"}, DW'(bad), '0);
    q.delete();
    rd_ready = 1'b0;
  endtask

  typedef struct {
    logic          wv;
    logic [DW-1:0] wd;
    logic          rr;
    logic          e_wrdy;
    logic          e_csa;
    logic [AW-1:0] e_aa;
    logic          e_csb;
    logic [AW-1:0] e_ab;
    logic          e_rv;
    logic [DW-1:0] e_rd;
    logic [AW+1:0] e_fill;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int n_in, n_out, bad, cyc, first_out, gaps, saw_wrap, last_wa, max_pf, k, stale, same_addr;

    //           wv  wd       rr  wrdy csa aa csb ab rv rd       fill
    vecs[0]  = '{1, 128'hA5, 0,  1,   1,  0, 0,  0, 0, 0,       0};
    vecs[1]  = '{0, 0,       0,  1,   0,  0, 1,  0, 0, 0,       1};
    vecs[2]  = '{0, 0,       0,  1,   0,  0, 0,  0, 0, 0,       1};
    vecs[3]  = '{0, 0,       0,  1,   0,  0, 0,  0, 0, 0,       1};
    vecs[4]  = '{0, 0,       1,  1,   0,  0, 0,  0, 1, 128'hA5, 1};
    vecs[5]  = '{0, 0,       0,  1,   0,  0, 0,  0, 0, 0,       0};
    vecs[6]  = '{1, 128'hB1, 0,  1,   1,  1, 0,  0, 0, 0,       0};
    vecs[7]  = '{1, 128'hB2, 1,  1,   1,  2, 1,  1, 0, 0,       1};
    vecs[8]  = '{0, 0,       1,  1,   0,  2, 1,  2, 0, 0,       2};
    vecs[9]  = '{0, 0,       1,  1,   0,  2, 0,  2, 0, 0,       2};
    vecs[10] = '{0, 0,       1,  1,   0,  2, 0,  2, 1, 128'hB1, 2};
    vecs[11] = '{0, 0,       1,  1,   0,  2, 0,  2, 1, 128'hB2, 1};
    vecs[12] = '{0, 0,       1,  1,   0,  2, 0,  2, 0, 0,       0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset.wr_ready", DW'(wr_ready), 1);
    chk("reset.rd_valid", DW'(rd_valid), 0);
    chk("reset.csa_csb", DW'({CSA_F, WEA_F, CSB_F, REB_F}), 0);
    chk("reset.fill", DW'(fill_level), 0);
    chk("reset.stats", DW'({sbit_cnt, dbit_cnt, ecc_fault_sticky}), 0);
    chk("reset.addr", DW'({AA_F, AB_F}), 0);
    chk("reset.da", DA_F, 0);
    chk("reset.rd_data", rd_data, 0);

    for (int i = 0; i < 13; i++) begin
      wr_valid = vecs[i].wv;
      wr_data  = vecs[i].wd;
      rd_ready = vecs[i].rr;
      #1;
      chk($sformatf("vec%0d.wr_ready", i), DW'(wr_ready), DW'(vecs[i].e_wrdy));
      chk($sformatf("vec%0d.csa", i), DW'({CSA_F, WEA_F}), DW'({2{vecs[i].e_csa}}));
      chk($sformatf("vec%0d.aa", i), DW'(AA_F), DW'(vecs[i].e_aa));
      chk($sformatf("vec%0d.csb", i), DW'({CSB_F, REB_F}), DW'({2{vecs[i].e_csb}}));
      chk($sformatf("vec%0d.ab", i), DW'(AB_F), DW'(vecs[i].e_ab));
      chk($sformatf("vec%0d.rd_valid", i), DW'(rd_valid), DW'(vecs[i].e_rv));
      if (vecs[i].e_rv) chk($sformatf("vec%0d.rd_data", i), rd_data, vecs[i].e_rd);
      chk($sformatf("vec%0d.fill", i), DW'(fill_level), DW'(vecs[i].e_fill));
      step();
    end
    wr_valid = 1'b0;
    rd_ready = 1'b0;

    // Fill to full with the consumer stalled.
    n_in = 0; cyc = 0; same_addr = 0;
    while (cyc < 3000) begin
      wr_valid = 1'b1;
      wr_data  = DW'(32'hF00D_0000 + n_in);
      #1;
      if (CSA_F && CSB_F && AB_F == AA_F) same_addr++;
      if (!wr_ready) break;
      q.push_back(wr_data);
      n_in++;
      step();
      cyc++;
    end
    chk("full.accepted", DW'(n_in), 2052);
    chk("full.fill", DW'(fill_level), 2052);
    chk("full.same_addr", DW'(same_addr), 0);
    step();
    #1;
    chk("full.wr_ready_held", DW'(wr_ready), 0);
    chk("full.rd_valid", DW'(rd_valid), 1);
    drain("full.drain", 2200);

    // Streaming with wrap-around at one word per cycle.
    n_in = 0; n_out = 0; bad = 0; cyc = 0; first_out = -1; gaps = 0; saw_wrap = 0; last_wa = -1;
    rd_ready = 1'b1;
    while (n_out < 5000 && cyc < 6000) begin
      wr_valid = (n_in < 5000);
      wr_data  = DW'(32'hC000_0000 + n_in);
      #1;
      if (wr_valid && wr_ready) begin
        if (last_wa == DEPTH - 1 && int'(AA_F) == 0) saw_wrap = 1;
        last_wa = int'(AA_F);
        q.push_back(wr_data);
        n_in++;
      end
      if (rd_valid) begin
        if (first_out < 0) first_out = cyc;
        if (q.size() == 0 || rd_data !== q[0]) bad++;
        if (q.size() > 0) void'(q.pop_front());
        n_out++;
      end else if (first_out >= 0) begin
        gaps++;
      end
      step();
      cyc++;
    end
    chk("wrap.popped", DW'(n_out), 5000);
    chk("wrap.order_errs", DW'(bad), 0);
    chk("wrap.first_latency", DW'(first_out), 4);
    chk("wrap.gaps", DW'(gaps), 0);
    chk("wrap.addr_wrapped", DW'(saw_wrap), 1);
    drain("wrap.drain", 50);

    // ECC tagging on the 3rd and 5th returns.
    inj_s = ret_cnt + 2;
    inj_d = ret_cnt + 4;
    for (int i = 0; i < 6; i++) begin
      wr_valid = 1'b1;
      wr_data  = DW'(32'hECC0 + i);
      q.push_back(wr_data);
      step();
    end
    wr_valid = 1'b0;
    repeat (6) step();
    rd_ready = 1'b1; k = 0; cyc = 0;
    while (k < 6 && cyc < 50) begin
      #1;
      if (rd_valid) begin
        chk($sformatf("ecc.pop%0d.data", k + 1), rd_data, q[0]);
        chk($sformatf("ecc.pop%0d.sbit", k + 1), DW'(rd_sbit_err), DW'(k == 2));
        chk($sformatf("ecc.pop%0d.dbit", k + 1), DW'(rd_dbit_err), DW'(k == 4));
        chk($sformatf("ecc.pop%0d.fault", k + 1), DW'(rd_ecc_fault), DW'(k == 4));
        void'(q.pop_front());
        k++;
      end
      step();
      cyc++;
    end
    rd_ready = 1'b0;
    inj_s = -1;
    inj_d = -1;
    q.delete();
    chk("ecc.pops", DW'(k), 6);
    #1;
    chk("ecc.sbit_cnt", DW'(sbit_cnt), 1);
    chk("ecc.dbit_cnt", DW'(dbit_cnt), 1);
    chk("ecc.sticky", DW'(ecc_fault_sticky), 1);
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    #1;
    chk("clr.stats", DW'({sbit_cnt, dbit_cnt, ecc_fault_sticky}), 0);

    // stat_clr wins over an increment in the same cycle.
    inj_s = ret_cnt;
    wr_valid = 1'b1;
    wr_data  = DW'(32'h5EED);
    step();
    wr_valid = 1'b0;
    cyc = 0;
    #1;
    while (!rd_valid && cyc < 20) begin
      step();
      #1;
      cyc++;
    end
    chk("clrprio.flagged", DW'({rd_valid, rd_sbit_err}), DW'(2'b11));
    rd_ready = 1'b1;
    stat_clr = 1'b1;
    step();
    rd_ready = 1'b0;
    stat_clr = 1'b0;
    inj_s = -1;
    #1;
    chk("clrprio.sbit_cnt", DW'(sbit_cnt), 0);
    chk("clrprio.empty", DW'(fill_level), 0);

    // Random backpressure, 30% stall.
    n_in = 0; n_out = 0; bad = 0; cyc = 0; max_pf = 0;
    while (n_out < 400 && cyc < 3000) begin
      wr_valid = (n_in < 400);
      wr_data  = DW'(32'hBB00_0000 + n_in);
      rd_ready = ($urandom_range(0, 99) >= 30);
      #1;
      if (int'(dut.pf_cnt) > max_pf) max_pf = int'(dut.pf_cnt);
      if (wr_valid && wr_ready) begin
        q.push_back(wr_data);
        n_in++;
      end
      if (rd_valid && rd_ready) begin
        if (q.size() == 0 || rd_data !== q[0]) bad++;
        if (q.size() > 0) void'(q.pop_front());
        n_out++;
      end
      step();
      cyc++;
    end
    chk("bp.popped", DW'(n_out), 400);
    chk("bp.order_errs", DW'(bad), 0);
    chk("bp.max_pf_le4", DW'(max_pf <= 4), 1);
    drain("bp.drain", 50);

    // Reset with two reads in flight.
    wr_valid = 1'b1; wr_data = DW'(32'hDEAD_0001);
    step();
    wr_data = DW'(32'hDEAD_0002);
    step();
    wr_valid = 1'b0;
    step();
    #1;
    chk("rstmid.pre_fill", DW'(fill_level), 2);
    rst = 1'b1;
    #1;
    chk("rstmid.fill", DW'(fill_level), 0);
    chk("rstmid.rd_valid", DW'(rd_valid), 0);
    chk("rstmid.wr_ready", DW'(wr_ready), 1);
    chk("rstmid.strobes", DW'({CSA_F, WEA_F, CSB_F, REB_F}), 0);
    chk("rstmid.addr", DW'({AA_F, AB_F}), 0);
    chk("rstmid.rd_data", rd_data, 0);
    step();
    rst = 1'b0;
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (rd_valid || fill_level != '0) stale++;
      step();
    end
    chk("rstmid.stale_returns", DW'(stale), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
